// File: rtl/mmio_peripheral_hub.sv
// mmio_peripheral_hub: 256-byte MMIO window with output registers, synchronised switches with sticky edges, and a compare timer
module mmio_peripheral_hub #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00,
  parameter int NUM_OUT = 4,
  parameter int SW_WIDTH = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic                   we,
  output logic [31:0]            rdata,
  output logic                   hit,
  input  logic [SW_WIDTH-1:0]    sw_in,
  output logic [NUM_OUT*32-1:0]  out_bus,
  output logic                   timer_irq
);
  localparam logic [5:0] W_SW   = 6'h10;
  localparam logic [5:0] W_EDGE = 6'h11;
  localparam logic [5:0] W_CNT  = 6'h12;
  localparam logic [5:0] W_CMP  = 6'h13;
  localparam logic [5:0] W_CTRL = 6'h14;
  logic [NUM_OUT-1:0][31:0]             out_r;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sync_ff;
  logic [SW_WIDTH-1:0]                  sync, sync_d, sw_edge;
  logic [TIMER_WIDTH-1:0]               tcount, tcmp;
  logic                                 en, ar, ie, flag;
  logic [5:0]                           idx;
  logic                                 wr, match;
  logic [31:0]                          rd_word;
  assign idx       = addr[7:2];
  assign hit       = addr[31:8] == BASE_ADDR[31:8] && addr[1:0] == 2'b00;
  assign wr        = we && hit;
  assign sync      = sync_ff[SYNC_STAGES-1];
  assign match     = en && tcount == tcmp;
  assign out_bus   = out_r;
  assign timer_irq = flag & ie;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (wr && idx == 6'(i)) out_r[i] <= wdata;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
      sync_d  <= '0;
      sw_edge <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw_in};
      sync_d  <= sync;
      sw_edge <= (sw_edge & ~(wr && idx == W_EDGE ? wdata[SW_WIDTH-1:0] : '0)) | (sync & ~sync_d);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount <= '0;
      tcmp   <= '1;
      {ie, ar, en} <= 3'b000;
      flag   <= 1'b0;
    end else begin
      tcount <= wr && idx == W_CNT ? wdata[TIMER_WIDTH-1:0] : match && ar ? '0 : en ? tcount + 1'b1 : tcount;
      flag   <= match | (flag & ~(wr && idx == W_CTRL && wdata[3]));
      if (wr && idx == W_CMP) tcmp <= wdata[TIMER_WIDTH-1:0];
      if (wr && idx == W_CTRL) {ie, ar, en} <= wdata[2:0];
    end
  end
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (idx == 6'(i)) rd_word = out_r[i];
    if (idx == W_SW) rd_word = 32'(sync);
    if (idx == W_EDGE) rd_word = 32'(sw_edge);
    if (idx == W_CNT) rd_word = 32'(tcount);
    if (idx == W_CMP) rd_word = 32'(tcmp);
    if (idx == W_CTRL) rd_word = {28'b0, flag, ie, ar, en};
    rdata = hit ? rd_word : '0;
  end
endmodule

// File: tb/tb_mmio_peripheral_hub.sv
// tb_mmio_peripheral_hub: directed and random checks of the MMIO hub against a behavioural model
module tb_mmio_peripheral_hub;
  localparam logic [31:0] BASE = 32'hFFFFFF00;
  localparam int NUM_OUT = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic we = 1'b0, hit, timer_irq;
  logic [9:0] sw_in = '0;
  logic [127:0] out_bus;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mmio_peripheral_hub #(.BASE_ADDR(BASE), .NUM_OUT(NUM_OUT), .SW_WIDTH(10), .SYNC_STAGES(2), .TIMER_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .hit(hit), .sw_in(sw_in), .out_bus(out_bus), .timer_irq(timer_irq)
  );
  // model state: sw history h0 = last sample, h1 = synchronised value, h2 = its delay
  logic [31:0] mout [NUM_OUT];
  logic [9:0] h0, h1, h2, medge;
  logic [7:0] mcnt, mcmp;
  logic men, mar, mie, mflag;
  logic mw, mm;
  logic [7:0] moff;
  function automatic logic mhit(input logic [31:0] a);
    return a[31:8] == BASE[31:8] && a[1:0] == 2'b00;
  endfunction
  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [7:0] o;
    o = a[7:0];
    if (!mhit(a)) return 32'h0;
    if (o < 8'(4 * NUM_OUT)) return mout[o / 4];
    case (o)
      8'h40: return {22'b0, h1};
      8'h44: return {22'b0, medge};
      8'h48: return {24'b0, mcnt};
      8'h4C: return {24'b0, mcmp};
      8'h50: return {28'b0, mflag, mie, mar, men};
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) mout[i] = 32'h0;
      {h0, h1, h2, medge} = '0;
      mcnt = 8'h00;
      mcmp = 8'hFF;
      {men, mar, mie, mflag} = 4'b0000;
    end else begin
      mw = we && mhit(addr);
      moff = addr[7:0];
      mm = men && mcnt == mcmp;
      medge = (medge & ~(mw && moff == 8'h44 ? wdata[9:0] : 10'h0)) | (h1 & ~h2);
      h2 = h1;
      h1 = h0;
      h0 = sw_in;
      if (mw && moff == 8'h48) mcnt = wdata[7:0];
      else if (mm && mar) mcnt = 8'h00;
      else if (men) mcnt = mcnt + 8'h01;
      mflag = mm || (mflag && !(mw && moff == 8'h50 && wdata[3]));
      if (mw && moff == 8'h50) {mie, mar, men} = wdata[2:0];
      if (mw && moff == 8'h4C) mcmp = wdata[7:0];
      if (mw && moff < 8'(4 * NUM_OUT)) mout[moff / 4] = wdata;
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("hit", 128'(hit), 128'(mhit(addr)));
    chk("rdata", 128'(rdata), 128'(mread(addr)));
    chk("out_bus", out_bus, {mout[3], mout[2], mout[1], mout[0]});
    chk("timer_irq", 128'(timer_irq), 128'(mflag && mie));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic look(input logic [31:0] a);
    addr = a;
    #1;
  endtask
  int seq [7] = '{0, 1, 2, 3, 4, 0, 1};
  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    chk("rst_out_bus", out_bus, 128'h0);
    look(BASE + 32'h4C);
    chk("rst_tcmp", 128'(rdata), 128'hFF);
    wr(BASE + 32'h08, 32'h00ABCDEF);
    chk("out2_bus", 128'(out_bus[95:64]), 128'h00ABCDEF);
    look(BASE + 32'h08);
    chk("out2_read", 128'(rdata), 128'h00ABCDEF);
    look(BASE + 32'h0E);
    chk("misaligned_hit", 128'(hit), 128'h0);
    wr(BASE + 32'h0E, 32'hDEADBEEF);
    wr(BASE + 32'h30, 32'h12345678);
    chk("no_change_bus", out_bus, 128'h00ABCDEF << 64);
    look(BASE - 32'h4);
    chk("below_hit", 128'(hit), 128'h0);
    look(BASE + 32'hFC);
    chk("top_hit", 128'(hit), 128'h1);
    chk("top_rdata", 128'(rdata), 128'h0);
    wr(BASE + 32'h4C, 32'h4);
    wr(BASE + 32'h48, 32'h0);
    wr(BASE + 32'h50, 32'h7);
    look(BASE + 32'h48);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      chk("reload_seq", 128'(rdata), 128'(seq[k]));
      chk("reload_irq", 128'(timer_irq), 128'(k >= 5));
    end
    wr(BASE + 32'h50, 32'hF);
    chk("w1c_irq", 128'(timer_irq), 128'h0);
    tick();
    tick();
    wr(BASE + 32'h50, 32'hF);
    chk("w1c_match_irq", 128'(timer_irq), 128'h1);
    chk("w1c_match_ctrl", 128'(rdata), 128'hF);
    wr(BASE + 32'h50, 32'h8);
    wr(BASE + 32'h4C, 32'h10);
    wr(BASE + 32'h48, 32'hFE);
    wr(BASE + 32'h50, 32'h1);
    look(BASE + 32'h48);
    chk("wrap_fe", 128'(rdata), 128'hFE);
    tick();
    chk("wrap_ff", 128'(rdata), 128'hFF);
    tick();
    chk("wrap_00", 128'(rdata), 128'h00);
    wr(BASE + 32'h48, 32'h20);
    chk("load_override", 128'(rdata), 128'h20);
    tick();
    chk("load_inc", 128'(rdata), 128'h21);
    sw_in = 10'h008;
    look(BASE + 32'h40);
    tick();
    chk("sw_lat1", 128'(rdata), 128'h0);
    tick();
    chk("sw_lat2", 128'(rdata), 128'h8);
    look(BASE + 32'h44);
    chk("edge_lat2", 128'(rdata), 128'h0);
    tick();
    chk("edge_lat3", 128'(rdata), 128'h8);
    sw_in = 10'h000;
    wr(BASE + 32'h44, 32'h8);
    chk("edge_w1c", 128'(rdata), 128'h0);
    repeat (3) tick();
    sw_in = 10'h008;
    tick();
    tick();
    wr(BASE + 32'h44, 32'h8);
    chk("edge_set_wins", 128'(rdata), 128'h8);
    sw_in = 10'h3FF;
    look(BASE + 32'h48);
    #1 reset = 1'b0;
    #1;
    chk("async_bus", out_bus, 128'h0);
    chk("async_irq", 128'(timer_irq), 128'h0);
    chk("async_tcount", 128'(rdata), 128'h0);
    addr = BASE + 32'h4C;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("post_tcmp", 128'(rdata), 128'hFF);
    look(BASE + 32'h44);
    chk("post_edge0", 128'(rdata), 128'h0);
    tick();
    chk("post_edge1", 128'(rdata), 128'h0);
    for (int n = 0; n < 3000; n++) begin
      tick();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr = BASE + 32'(4 * $urandom_range(0, 21));
        5: addr = BASE + 32'hFC;
        6: addr = BASE + 32'($urandom_range(0, 255));
        7: addr = BASE - 32'h4;
        8: addr = $urandom;
        default: addr = BASE + ($urandom_range(0, 1) ? 32'h48 : 32'h4C);
      endcase
      wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20));
      we = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #1;
        chk("rand_async_bus", out_bus, 128'h0);
        chk("rand_async_irq", 128'(timer_irq), 128'h0);
        @(posedge clk);
        #3 reset = 1'b1;
      end
    end
    we = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
